// File: rtl/lif_core_param.sv
// rtl/lif_core_param.sv - parametrised leaky integrate-and-fire neuron core with run-time weight RAM
module lif_core_param #(
  parameter int NEURONS = 10,
  parameter int PRESYN  = 10,
  parameter int W       = 16,
  parameter int FRAC    = 14,
  parameter int REFR_W  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_core,
  input  logic                       spk_valid_i,
  input  logic [$clog2(PRESYN)-1:0]  spk_idx_i,
  output logic                       spk_ready_o,
  input  logic                       step_valid_i,
  output logic                       step_ready_o,
  input  logic                       wgt_we_i,
  input  logic [$clog2(PRESYN)-1:0]  wgt_pre_i,
  input  logic [$clog2(NEURONS)-1:0] wgt_post_i,
  input  logic signed [W-1:0]        wgt_data_i,
  input  logic signed [W-1:0]        thresh_i,
  input  logic [3:0]                 leak_shift_i,
  input  logic                       reset_sub_i,
  input  logic [REFR_W-1:0]          refrac_i,
  output logic                       out_valid_o,
  output logic [$clog2(NEURONS)-1:0] out_idx_o,
  input  logic                       out_ready_i,
  output logic                       busy_o,
  output logic [15:0]                timestep_o
);

  localparam int NI = $clog2(NEURONS);
  localparam int PI = $clog2(PRESYN);
  localparam logic [NI-1:0] LAST_N = NI'(NEURONS - 1);

  // FRAC only names the Q format; add, subtract and arithmetic shift do not depend on it.
  if (FRAC < 0 || FRAC >= W) begin : g_frac_out_of_range
  end

  typedef enum logic [1:0] {IDLE, INTEG, FIRE} state_t;

  state_t              state_q, state_d;
  logic [NI-1:0]       n_q, n_d;
  logic [PI-1:0]       pre_q, pre_d;
  logic signed [W-1:0] v_q [NEURONS];
  logic signed [W-1:0] v_d [NEURONS];
  logic [REFR_W-1:0]   refr_q [NEURONS];
  logic [REFR_W-1:0]   refr_d [NEURONS];
  logic signed [W-1:0] wgt_q [PRESYN][NEURONS];
  logic signed [W-1:0] wgt_d [PRESYN][NEURONS];
  logic                out_valid_q, out_valid_d;
  logic [NI-1:0]       out_idx_q, out_idx_d;
  logic [15:0]         ts_q, ts_d;

  logic signed [W-1:0] v_cur, w_cur, leak_sh, leaked, v_sum, v_sub;
  logic [REFR_W-1:0]   refr_cur;
  logic                fire, out_free, advance;

  // Clamp a one-bit-wider result back into the W-bit signed range
  function automatic logic signed [W-1:0] sat(input logic signed [W:0] x);
    if (x[W] != x[W-1]) begin
      sat = x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sat = x[W-1:0];
    end
  endfunction

  assign v_cur    = v_q[n_q];
  assign w_cur    = wgt_q[pre_q][n_q];
  assign refr_cur = refr_q[n_q];
  // Leak moves v toward zero, so v - (v >>> s) cannot overflow
  assign leak_sh  = v_cur >>> leak_shift_i;
  assign leaked   = (leak_shift_i == 4'd0) ? v_cur : v_cur - leak_sh;
  assign v_sum    = sat({v_cur[W-1], v_cur} + {w_cur[W-1], w_cur});
  assign v_sub    = sat({leaked[W-1], leaked} - {thresh_i[W-1], thresh_i});
  assign fire     = (refr_cur == '0) && (leaked >= thresh_i);
  assign out_free = !out_valid_q || out_ready_i;

  assign spk_ready_o  = (state_q == IDLE) && en_core && !rst_i;
  assign step_ready_o = (state_q == IDLE) && en_core && !spk_valid_i && !rst_i;
  assign busy_o       = (state_q != IDLE);
  assign out_valid_o  = out_valid_q;
  assign out_idx_o    = out_idx_q;
  assign timestep_o   = ts_q;

  // Next-state: request acceptance, per-neuron integrate/fire walk, output register
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    pre_d       = pre_q;
    v_d         = v_q;
    refr_d      = refr_q;
    wgt_d       = wgt_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    ts_d        = ts_q;
    advance     = 1'b0;

    // Consumer handshake drains the register in any state; a same-cycle fire reloads it below
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (wgt_we_i) wgt_d[wgt_pre_i][wgt_post_i] = wgt_data_i;
        if (en_core && spk_valid_i) begin
          pre_d   = spk_idx_i;
          n_d     = '0;
          state_d = INTEG;
        end else if (en_core && step_valid_i) begin
          n_d     = '0;
          state_d = FIRE;
        end
      end
      INTEG: begin
        if (refr_cur == '0) v_d[n_q] = v_sum;
        if (n_q == LAST_N) begin
          n_d     = '0;
          state_d = IDLE;
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      FIRE: begin
        if (refr_cur != '0) begin
          refr_d[n_q] = refr_cur - 1'b1;
          v_d[n_q]    = leaked;
          advance     = 1'b1;
        end else if (fire) begin
          // A fire waits for room in the output register; neuron state stays put while stalled
          if (out_free) begin
            v_d[n_q]    = reset_sub_i ? v_sub : '0;
            refr_d[n_q] = refrac_i;
            out_valid_d = 1'b1;
            out_idx_d   = n_q;
            advance     = 1'b1;
          end
        end else begin
          v_d[n_q] = leaked;
          advance  = 1'b1;
        end
        if (advance) begin
          if (n_q == LAST_N) begin
            n_d     = '0;
            ts_d    = ts_q + 16'd1;
            state_d = IDLE;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, neuron array and weight RAM registers; reset clears everything at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      n_q         <= '0;
      pre_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      ts_q        <= '0;
      for (int i = 0; i < NEURONS; i++) begin
        v_q[i]    <= '0;
        refr_q[i] <= '0;
      end
      for (int p = 0; p < PRESYN; p++) begin
        for (int j = 0; j < NEURONS; j++) begin
          wgt_q[p][j] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      pre_q       <= pre_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      ts_q        <= ts_d;
      v_q         <= v_d;
      refr_q      <= refr_d;
      wgt_q       <= wgt_d;
    end
  end

endmodule
